// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the MEM-stage sequencer, its timeout
// counter and the dmem bus interface.
//   st_e   : sequencer state encoding (IDLE, BUSY, DONE, ERR)
//   DATA_W : address / data width of the core
package mips_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } st_e;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if: request/acknowledge bus between the MEM-stage sequencer
// and the multi-cycle data memory.
//   req, we, addr, wdata : sequencer -> memory, held stable while req = 1
//   ack, rdata           : memory -> sequencer, rdata valid in the ack cycle
// Modports: master (sequencer side), slave (memory side).
interface mem_stage_ctrl_if;
  import mips_pkg::*;

  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_timeout_cnt.sv
// mem_timeout_cnt: saturating cycle counter for the dmem access watchdog.
//   clk, rst  : clock, asynchronous active-high reset
//   clr_i     : synchronous clear (wins over en_i)
//   en_i      : count one cycle
//   expired_o : counter has reached MAX_CNT (stays there until cleared)
module mem_timeout_cnt #(
  parameter int unsigned MAX_CNT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != 16'(MAX_CNT)))
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;

  assign expired_o = (cnt_q == 16'(MAX_CNT));

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage sequencer. Runs one req/ack transaction per load
// or store sitting in the EX/MEM register and stalls the pipeline meanwhile.
//   CLK, rst               : clock, asynchronous active-high reset
//   MemWriteM, MemtoRegM   : store / load in MEM (both set = store)
//   ALUOutM, WriteDataM    : byte address, store data
//   dmem (master)          : request/acknowledge bus to data memory
//   ReadDataM              : last completed load data (registered)
//   StallM                 : combinational freeze for PC, F/D, D/E, E/M
//   bus_err                : one-cycle pulse on an aborted access
// Build option: MEM_STAGE_CTRL_TIMEOUT_EN adds the watchdog that aborts an
// access after TIMEOUT_CYCLES BUSY cycles with no ack; without it BUSY waits
// forever and bus_err is constant 0.
module mem_stage_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYCLES = 16,
  parameter logic [DATA_W-1:0] ERR_DATA       = 32'h0000_0000
) (
  input  logic                   CLK,
  input  logic                   rst,
  input  logic                   MemWriteM,
  input  logic                   MemtoRegM,
  input  logic [DATA_W-1:0]      ALUOutM,
  input  logic [DATA_W-1:0]      WriteDataM,
  mem_stage_ctrl_if.master       dmem,
  output logic [DATA_W-1:0]      ReadDataM,
  output logic                   StallM,
  output logic                   bus_err
);

  st_e               state_q;
  logic              req_q, we_q, err_q;
  logic [DATA_W-1:0] addr_q, wdata_q, rdata_q;
  logic              mem_op, tmo_expired;

  assign mem_op = MemWriteM | MemtoRegM;

`ifdef MEM_STAGE_CTRL_TIMEOUT_EN
  // Cleared on the IDLE->BUSY edge so the first BUSY cycle sees 0.
  mem_timeout_cnt #(.MAX_CNT(TIMEOUT_CYCLES - 1)) u_tmo (
    .clk       (CLK),
    .rst       (rst),
    .clr_i     ((state_q == IDLE) && mem_op),
    .en_i      (state_q == BUSY),
    .expired_o (tmo_expired)
  );
  assign bus_err = err_q;
`else
  logic unused_cfg;
  assign tmo_expired = 1'b0;
  assign bus_err     = 1'b0;
  assign unused_cfg  = err_q ^ (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: if (mem_op) begin
          addr_q  <= ALUOutM;
          wdata_q <= WriteDataM;
          we_q    <= MemWriteM;     // store wins when both are set
          req_q   <= 1'b1;
          state_q <= BUSY;
        end
        BUSY: if (dmem.ack) begin
          if (!we_q) rdata_q <= dmem.rdata;
          req_q   <= 1'b0;
          state_q <= DONE;
        end else if (tmo_expired) begin
          // Error data is visible during ERR, the cycle MEM/WB captures it.
          if (!we_q) rdata_q <= ERR_DATA;
          req_q   <= 1'b0;
          err_q   <= 1'b1;
          state_q <= ERR;
        end
        default: state_q <= IDLE;   // DONE, ERR: one advance cycle
      endcase
    end
  end

  assign StallM     = ((state_q == IDLE) && mem_op) || (state_q == BUSY);
  assign dmem.req   = req_q;
  assign dmem.we    = we_q;
  assign dmem.addr  = addr_q;
  assign dmem.wdata = wdata_q;
  assign ReadDataM  = rdata_q;

endmodule
